// File: rtl/pll_clk_enable_gen.sv
// ----------------------------------------------------------------------------
// pll_clk_enable_gen
//
// Purpose:
//   Clock-enable generator and lock supervisor that sits behind the board PLL.
//   It debounces the PLL lock flag and holds every enable low until lock has
//   been stable long enough. It then produces NUM_CHANNELS phase-aligned,
//   single-cycle enables with run-time programmable divisor and phase. If lock
//   drops while running, it latches a sticky lock_lost flag for software.
//
// Ports:
//   refclk        in   fast PLL output clock
//   rst           in   asynchronous, active-high reset
//   pll_locked    in   PLL lock flag, asynchronous to refclk
//   cfg_wr        in   one-cycle configuration write strobe
//   cfg_sel       in   channel selected by the write
//   cfg_div       in   new divisor (0 disables the channel)
//   cfg_phase     in   new start phase
//   lock_lost_clr in   clears lock_lost
//   ce            out  per-channel single-cycle enables
//   locked        out  high while the block is running
//   lock_lost     out  sticky: lock dropped while running
//   cfg_err       out  one-cycle pulse after a write to a nonexistent channel
// ----------------------------------------------------------------------------
module pll_clk_enable_gen #(
    parameter  int NUM_CHANNELS  = 5,
    parameter  int DIV_WIDTH     = 16,
    parameter  int LOCK_DEBOUNCE = 1024,
    parameter  int DEFAULT_DIV   = 1,
    localparam int SEL_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic                    cfg_wr,
    input  logic [SEL_WIDTH-1:0]    cfg_sel,
    input  logic [DIV_WIDTH-1:0]    cfg_div,
    input  logic [DIV_WIDTH-1:0]    cfg_phase,
    input  logic                    lock_lost_clr,
    output logic [NUM_CHANNELS-1:0] ce,
    output logic                    locked,
    output logic                    lock_lost,
    output logic                    cfg_err
);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_SETTLING = 2'd1;
    localparam logic [1:0] ST_RUNNING  = 2'd2;

    localparam int                    DCNT_WIDTH = $clog2(LOCK_DEBOUNCE + 1);
    localparam logic [DCNT_WIDTH-1:0] DCNT_DONE  = DCNT_WIDTH'(LOCK_DEBOUNCE);
    localparam logic [DIV_WIDTH-1:0]  DEF_DIV    = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [SEL_WIDTH:0]    NUM_CH_EXT = (SEL_WIDTH + 1)'(NUM_CHANNELS);

    logic [1:0]              r_sync;
    logic [1:0]              r_state;
    logic [DCNT_WIDTH-1:0]   r_dcnt;
    logic                    r_lock_lost;
    logic                    r_cfg_err;

    logic                    w_lock_s;
    logic                    w_running;
    logic                    w_entering;
    logic                    w_sel_ok;
    logic [NUM_CHANNELS-1:0] w_ce;

    // ------------------------------------------------------------------------
    // Lock synchroniser
    // ------------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments, so r_sync[1]
    // takes the previous value of r_sync[0] and never the value being written.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], pll_locked};
        end
    end

    assign w_lock_s = r_sync[1];

    // ------------------------------------------------------------------------
    // Lock supervisor FSM
    // ------------------------------------------------------------------------
    // The transition edge out of SETTLING is also the edge on which every
    // channel counter loads its phase.
    assign w_running  = (r_state == ST_RUNNING);
    assign w_entering = (r_state == ST_SETTLING) && w_lock_s && (r_dcnt == DCNT_DONE);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state <= ST_UNLOCKED;
            r_dcnt  <= '0;
        end else begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (w_lock_s) begin
                        r_state <= ST_SETTLING;
                        r_dcnt  <= DCNT_WIDTH'(1);
                    end
                end
                ST_SETTLING: begin
                    if (!w_lock_s) begin
                        r_state <= ST_UNLOCKED;
                    end else if (r_dcnt == DCNT_DONE) begin
                        r_state <= ST_RUNNING;
                    end else begin
                        r_dcnt <= r_dcnt + DCNT_WIDTH'(1);
                    end
                end
                ST_RUNNING: begin
                    if (!w_lock_s) begin
                        r_state <= ST_UNLOCKED;
                    end
                end
                default: begin
                    r_state <= ST_UNLOCKED;
                end
            endcase
        end
    end

    // A loss event takes priority over a simultaneous clear.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_lock_lost <= 1'b0;
        end else if (w_running && !w_lock_s) begin
            r_lock_lost <= 1'b1;
        end else if (lock_lost_clr) begin
            r_lock_lost <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Configuration decode
    // ------------------------------------------------------------------------
    assign w_sel_ok = ({1'b0, cfg_sel} < NUM_CH_EXT);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_wr && !w_sel_ok;
        end
    end

    // ------------------------------------------------------------------------
    // Enable channels
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        logic [DIV_WIDTH-1:0] r_div;
        logic [DIV_WIDTH-1:0] r_phase;
        logic [DIV_WIDTH-1:0] r_sh_div;
        logic [DIV_WIDTH-1:0] r_sh_phase;
        logic [DIV_WIDTH-1:0] r_cnt;

        logic w_div_zero;
        logic w_wrap;
        logic w_apply;
        logic w_wr_hit;

        assign w_div_zero = (r_div == '0);
        assign w_wrap     = w_running && !w_div_zero && (r_cnt == r_div - DIV_WIDTH'(1));
        // Outside RUNNING, or with the channel disabled, there is no period to
        // protect, so the active registers simply track the shadow copy.
        assign w_apply    = !w_running || w_div_zero || w_wrap;
        assign w_wr_hit   = cfg_wr && w_sel_ok && (cfg_sel == SEL_WIDTH'(g));

        // The last cycle of a period is dropped the moment the synchronised
        // lock falls, before the FSM has left RUNNING.
        assign w_ce[g] = w_wrap && w_lock_s;

        // NOTE: the configuration registers are flops with architectural reset
        // values, so they take the async reset; this is not a RAM, and leaving
        // them unreset would let a reset keep stale divisors.
        always_ff @(posedge refclk or posedge rst) begin
            if (rst) begin
                r_sh_div   <= DEF_DIV;
                r_sh_phase <= '0;
            end else if (w_wr_hit) begin
                r_sh_div   <= cfg_div;
                r_sh_phase <= cfg_phase;
            end
        end

        // A write that lands in the same cycle as an apply stays in the shadow
        // registers and is applied at the following wrap.
        always_ff @(posedge refclk or posedge rst) begin
            if (rst) begin
                r_div   <= DEF_DIV;
                r_phase <= '0;
            end else if (w_apply) begin
                r_div   <= r_sh_div;
                r_phase <= r_sh_phase;
            end
        end

        // At lock, the counter starts at the phase. If the phase is not below
        // the divisor, it is treated as 0. Any later apply restarts the count
        // from 0, so a new divisor never produces a runt pulse.
        always_ff @(posedge refclk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_entering) begin
                r_cnt <= (r_phase >= r_div) ? '0 : r_phase;
            end else if (w_running) begin
                if (w_apply) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + DIV_WIDTH'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all decoded from registers only
    // ------------------------------------------------------------------------
    assign ce        = w_ce;
    assign locked    = w_running;
    assign lock_lost = r_lock_lost;
    assign cfg_err   = r_cfg_err;

endmodule
